// File: rtl/raycast_pkg.sv
// raycast_pkg
// Shared types and defaults for the raycaster back end (process_element and
// column_renderer). A column result is packed as {color, height, y_side}.
package raycast_pkg;

    localparam int SCREEN_WIDTH_DEF  = 800;
    localparam int SCREEN_HEIGHT_DEF = 600;

    typedef struct packed {
        logic [7:0] color;
        logic [9:0] height;
        logic       y_side;
    } column_t;

    // Column index width; never narrower than one bit.
    function automatic int col_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/column_ram.sv
// column_ram
// 1W/1R synchronous-read RAM holding both column banks. The address MSB is
// the bank bit, so each bank occupies a power-of-two half of the array.
// Ports:
//   i_clk    system clock
//   i_we     write enable
//   i_waddr  write address {bank, column}
//   i_wdata  column entry to store
//   i_raddr  read address {bank, column}
//   o_rdata  registered read data (one cycle after i_raddr)
module column_ram
    import raycast_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  column_t       i_wdata,
    input  logic [AW-1:0] i_raddr,
    output column_t       o_rdata
);

    column_t r_mem [0:(1<<AW)-1];
    column_t r_rdata;

    // No reset on the array or read port so the tools can map it to block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/column_renderer.sv
// column_renderer
// Collects one column result per screen column into a double-buffered store
// and expands it per pixel into ceiling / wall / floor for scanout. Banks
// swap only at frame_start and only when the write bank is complete.
// Ports:
//   i_clk, i_rst               clock, async active-high reset
//   i_col_valid / o_col_ready  column write handshake
//   i_color, i_height, i_y_side column result
//   i_frame_start              swap point (start of vertical blank)
//   i_pix_active, i_pix_x, i_pix_y  scanout request
//   o_pixel, o_pixel_valid     pixel result, 2-cycle latency
//   o_frame_ready              write bank full, waiting for swap
// Build option: define SIDE_SHADE_EN to draw y-facing wall sides at half
// brightness; otherwise y_side is stored but not used.
module column_renderer
    import raycast_pkg::*;
#(
    parameter int         SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int         SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter logic [7:0] CEIL_COLOR    = 8'h11,
    parameter logic [7:0] FLOOR_COLOR   = 8'h22
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_col_valid,
    output logic       o_col_ready,
    input  logic [7:0] i_color,
    input  logic [9:0] i_height,
    input  logic       i_y_side,
    input  logic       i_frame_start,
    input  logic       i_pix_active,
    input  logic [9:0] i_pix_x,
    input  logic [9:0] i_pix_y,
    output logic [7:0] o_pixel,
    output logic       o_pixel_valid,
    output logic       o_frame_ready
);

    localparam int              CW       = col_width(SCREEN_WIDTH);
    localparam int              AW       = CW + 1;
    localparam logic [CW-1:0]   LAST_COL = CW'(SCREEN_WIDTH - 1);
    localparam logic [9:0]      SR10     = 10'(SCREEN_HEIGHT);
    localparam logic [10:0]     SR11     = 11'(SCREEN_HEIGHT);
    localparam logic [10:0]     SW11     = 11'(SCREEN_WIDTH);

    // write side
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [CW-1:0] r_wr_col;
    logic          r_full;
    logic          r_col_ready;
    logic          w_xfer;
    logic          w_last;
    logic          w_swap;
    logic          w_full_nxt;
    column_t       w_wdata;

    // read side
    column_t       w_rd;
    logic          r_s0_act;
    logic          r_s0_oob;
    logic [9:0]    r_s0_y;
    logic [10:0]   w_top;
    logic [10:0]   w_bot;
    logic [7:0]    w_wall;
    logic [7:0]    r_pixel;
    logic          r_pixel_valid;

    assign w_xfer = i_col_valid & r_col_ready;
    assign w_last = (r_wr_col == LAST_COL);
    // Uses the registered full flag, so a final write landing in the same
    // cycle as frame_start waits for the following frame_start.
    assign w_swap = i_frame_start & r_full;

    always_comb begin
        w_full_nxt = r_full;
        if (w_swap) begin
            w_full_nxt = 1'b0;
        end else if (w_xfer && w_last) begin
            w_full_nxt = 1'b1;
        end
    end

    always_comb begin
        w_wdata.color  = i_color;
        w_wdata.height = (i_height > SR10) ? SR10 : i_height;
        w_wdata.y_side = i_y_side;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b1;
            r_wr_col    <= '0;
            r_full      <= 1'b0;
            r_col_ready <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            r_col_ready <= ~w_full_nxt;
            if (w_xfer) begin
                r_wr_col <= w_last ? '0 : r_wr_col + 1'b1;
            end
            if (w_swap) begin
                r_rd_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    column_ram #(
        .AW (AW)
    ) u_column_ram (
        .i_clk   (i_clk),
        .i_we    (w_xfer),
        .i_waddr ({r_wr_bank, r_wr_col}),
        .i_wdata (w_wdata),
        .i_raddr ({r_rd_bank, CW'(i_pix_x)}),
        .o_rdata (w_rd)
    );

    // S0: request sideband registered alongside the RAM read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s0_act <= 1'b0;
            r_s0_oob <= 1'b0;
            r_s0_y   <= '0;
        end else begin
            r_s0_act <= i_pix_active;
            r_s0_oob <= ({1'b0, i_pix_x} >= SW11);
            r_s0_y   <= i_pix_y;
        end
    end

    // S1: wall span [top, bot), vertically centred. Height is clamped on
    // write, so SR - h never underflows.
    assign w_top = (SR11 - {1'b0, w_rd.height}) >> 1;
    assign w_bot = w_top + {1'b0, w_rd.height};

`ifdef SIDE_SHADE_EN
    assign w_wall = w_rd.y_side ? {1'b0, w_rd.color[7:1]} : w_rd.color;
`else
    logic w_unused_side;
    assign w_unused_side = w_rd.y_side;
    assign w_wall        = w_rd.color;
`endif

    // S2: registered pixel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_valid <= r_s0_act;
            if (!r_s0_act || r_s0_oob) begin
                r_pixel <= '0;
            end else if ({1'b0, r_s0_y} < w_top) begin
                r_pixel <= CEIL_COLOR;
            end else if ({1'b0, r_s0_y} < w_bot) begin
                r_pixel <= w_wall;
            end else begin
                r_pixel <= FLOOR_COLOR;
            end
        end
    end

    assign o_col_ready   = r_col_ready;
    assign o_frame_ready = r_full;
    assign o_pixel       = r_pixel;
    assign o_pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_column_renderer.sv
// tb_column_renderer
// Self-checking bench for column_renderer. Pixel expectations are pushed to a
// scoreboard queue when a scan request is driven and popped when the DUT
// presents a valid pixel. Honours SIDE_SHADE_EN the same way as the design.
module tb_column_renderer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       col_valid = 1'b0;
    logic       col_ready;
    logic [7:0] color = '0;
    logic [9:0] height = '0;
    logic       y_side = 1'b0;
    logic       frame_start = 1'b0;
    logic       pix_active = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [7:0] pixel;
    logic       pixel_valid;
    logic       frame_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];

    // write-bank contents being loaded, and the image currently displayed
    logic [7:0] wc[800];
    logic [9:0] wh[800];
    logic       ws[800];
    logic [7:0] disp_c[800];
    logic [9:0] disp_h[800];
    logic       disp_s[800];

    column_renderer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_col_valid   (col_valid),
        .o_col_ready   (col_ready),
        .i_color       (color),
        .i_height      (height),
        .i_y_side      (y_side),
        .i_frame_start (frame_start),
        .i_pix_active  (pix_active),
        .i_pix_x       (pix_x),
        .i_pix_y       (pix_y),
        .o_pixel       (pixel),
        .o_pixel_valid (pixel_valid),
        .o_frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_pix(input int x, input int y);
        int h;
        int top;
        int bot;
        logic [7:0] wall;
        if (x >= 800) return 8'h00;
        h   = (int'(disp_h[x]) > 600) ? 600 : int'(disp_h[x]);
        top = (600 - h) / 2;
        bot = top + h;
`ifdef SIDE_SHADE_EN
        wall = disp_s[x] ? {1'b0, disp_c[x][7:1]} : disp_c[x];
`else
        wall = disp_c[x];
`endif
        if (y < top) return 8'h11;
        if (y < bot) return wall;
        return 8'h22;
    endfunction

    // scoreboard pop side
    always @(negedge clk) begin
        if (pixel_valid) begin
            sb_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: pixel=%h appeared with nothing expected", pixel);
            end else begin
                e = sb_q.pop_front();
                if (pixel !== e.exp) begin
                    errors++;
                    $display("FAIL pixel x=%0d y=%0d got=%h exp=%h", e.x, e.y, pixel, e.exp);
                end
            end
        end
    end

    task automatic swap_model();
        for (int i = 0; i < 800; i++) begin
            disp_c[i] = wc[i];
            disp_h[i] = wh[i];
            disp_s[i] = ws[i];
        end
    endtask

    task automatic write_cols(input int first, input int last);
        int budget;
        for (int i = first; i <= last; i++) begin
            col_valid = 1'b1;
            color     = wc[i];
            height    = wh[i];
            y_side    = ws[i];
            budget    = 0;
            while (!col_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!col_ready) begin
                checks++;
                errors++;
                $display("FAIL write_timeout col=%0d col_ready=%b exp=1", i, col_ready);
                col_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        col_valid = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic scan(input int x, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            pix_active = 1'b1;
            pix_x      = 10'(x);
            pix_y      = 10'(y);
            sb_q.push_back('{x: x, y: y, exp: exp_pix(x, y)});
            @(negedge clk);
        end
        pix_active = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain x=%0d pending=%0d exp=0", x, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL reset_col_ready got=%b exp=0", col_ready); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset_frame_ready got=%b exp=0", frame_ready); end
        checks++; if (pixel !== 8'h00) begin errors++; $display("FAIL reset_pixel got=%h exp=00", pixel); end
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel_valid got=%b exp=0", pixel_valid); end
        rst = 1'b0;
        checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL release_col_ready_early got=%b exp=0", col_ready); end
        @(negedge clk);
        checks++; if (col_ready !== 1'b1) begin errors++; $display("FAIL release_col_ready got=%b exp=1", col_ready); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 800; i++) begin wc[i] = 8'h40; wh[i] = 10'd200; ws[i] = 1'b0; end
        write_cols(0, 799);
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL basic_frame_ready got=%b exp=1", frame_ready); end
        checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL basic_col_ready_full got=%b exp=0", col_ready); end
        pulse_fs();
        swap_model();
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL basic_frame_ready_swap got=%b exp=0", frame_ready); end
        checks++; if (col_ready !== 1'b1) begin errors++; $display("FAIL basic_col_ready_swap got=%b exp=1", col_ready); end
        scan(5, 0, 599);
        scan(0, 198, 201);
        scan(799, 398, 401);
        scan(850, 0, 3);
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL idle_pixel_valid got=%b exp=0", pixel_valid); end
        checks++; if (pixel !== 8'h00) begin errors++; $display("FAIL idle_pixel got=%h exp=00", pixel); end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 800; i++) begin wc[i] = 8'h5A; wh[i] = 10'd300; ws[i] = 1'b0; end
        wh[10] = 10'd700;
        wh[11] = 10'd0;
        wh[12] = 10'd600;
        wh[13] = 10'd1;
        write_cols(0, 799);
        pulse_fs();
        swap_model();
        scan(10, 0, 599);
        scan(11, 0, 599);
        scan(12, 0, 2);
        scan(12, 597, 599);
        scan(13, 298, 301);
    endtask

    task automatic test_full_hold();
        for (int i = 0; i < 800; i++) begin wc[i] = 8'h55; wh[i] = 10'd100; ws[i] = 1'b0; end
        write_cols(0, 799);
        col_valid = 1'b1;
        color     = 8'hEE;
        height    = 10'd50;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL hold_col_ready cyc=%0d got=%b exp=0", k, col_ready); end
            checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL hold_frame_ready cyc=%0d got=%b exp=1", k, frame_ready); end
        end
        col_valid = 1'b0;
        pulse_fs();
        swap_model();
        scan(0, 0, 2);
        scan(0, 248, 252);
        scan(0, 348, 352);
    endtask

    task automatic test_no_swap();
        for (int i = 0; i < 800; i++) begin wc[i] = 8'h77; wh[i] = 10'd400; ws[i] = 1'b0; end
        write_cols(0, 798);
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL partial_frame_ready got=%b exp=0", frame_ready); end
        pulse_fs();
        checks++; if (col_ready !== 1'b1) begin errors++; $display("FAIL partial_col_ready got=%b exp=1", col_ready); end
        scan(0, 248, 252);
        scan(798, 248, 252);
        // final column together with frame_start: no swap yet
        col_valid   = 1'b1;
        color       = wc[799];
        height      = wh[799];
        y_side      = ws[799];
        frame_start = 1'b1;
        @(negedge clk);
        col_valid   = 1'b0;
        frame_start = 1'b0;
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL same_cycle_frame_ready got=%b exp=1", frame_ready); end
        checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_col_ready got=%b exp=0", col_ready); end
        scan(0, 248, 252);
        pulse_fs();
        swap_model();
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL late_swap_frame_ready got=%b exp=0", frame_ready); end
        scan(0, 98, 102);
        scan(799, 498, 502);
    endtask

    task automatic test_shade();
        for (int i = 0; i < 800; i++) begin wc[i] = 8'hF0; wh[i] = 10'd300; ws[i] = (i % 2) == 0; end
        write_cols(0, 799);
        pulse_fs();
        swap_model();
        scan(2, 148, 152);
        scan(3, 148, 152);
        scan(801, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 800; i++) begin wc[i] = 8'(i); wh[i] = 10'd250; ws[i] = 1'b0; end
        write_cols(0, 399);
        pix_active = 1'b1;
        pix_x      = 10'd3;
        pix_y      = 10'd300;
        sb_q.push_back('{x: 3, y: 300, exp: exp_pix(3, 300)});
        @(negedge clk);
        sb_q.push_back('{x: 3, y: 300, exp: exp_pix(3, 300)});
        @(negedge clk);
        pix_active = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_col_ready got=%b exp=0", col_ready); end
        checks++; if (pixel !== 8'h00) begin errors++; $display("FAIL mid_rst_pixel got=%h exp=00", pixel); end
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_pixel_valid got=%b exp=0", pixel_valid); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_frame_ready got=%b exp=0", frame_ready); end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (col_ready !== 1'b1) begin errors++; $display("FAIL post_rst_col_ready got=%b exp=1", col_ready); end
        write_cols(0, 799);
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL post_rst_frame_ready got=%b exp=1", frame_ready); end
        pulse_fs();
        swap_model();
        scan(0, 174, 176);
        scan(1, 300, 300);
        scan(255, 300, 300);
        scan(400, 424, 425);
        scan(799, 424, 425);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_full_hold();
        test_no_swap();
        test_shade();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
